// File: rtl/messbauer_pkg.sv
// Definitions shared between the Mossbauer sweep generator and the spectrum collector.
package messbauer_pkg;
  localparam int CHANNEL_BEFORE = 1;
  localparam int CHANNEL_AFTER  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_OPEN,
    ST_DONE
  } state_t;
endpackage

// File: rtl/messbauer_spectrum_collector_if.sv
// Record stream from the collector to the spectrum memory (valid/ready).
interface messbauer_spectrum_collector_if #(
  parameter int CHANNEL_WIDTH = 10,
  parameter int COUNT_WIDTH   = 16
);
  logic                     out_valid;
  logic                     out_ready;
  logic [CHANNEL_WIDTH-1:0] out_channel;
  logic [COUNT_WIDTH-1:0]   out_count;

  modport master (output out_valid, out_channel, out_count, input  out_ready);
  modport slave  (input  out_valid, out_channel, out_count, output out_ready);
endinterface

// File: rtl/messbauer_pulse_sync.sv
// Optional 2-flop synchronizer followed by a rising-edge detector.
module messbauer_pulse_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);
  logic s, s_q;

  generate
    if (SYNC_STAGES == 2) begin : g_sync
      logic [1:0] meta;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) meta <= '0;
        else        meta <= {meta[0], din};
      assign s = meta[1];
    end else begin : g_direct
      assign s = din;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) s_q <= 1'b0;
    else        s_q <= s;

  assign rise = s & ~s_q;
endmodule

// File: rtl/messbauer_spectrum_collector.sv
// Counts detector events per velocity channel and streams (channel, count) records,
// checking sweep framing against the generator's start/channel pulses.
module messbauer_spectrum_collector
  import messbauer_pkg::*;
#(
  parameter int CHANNEL_NUMBER = 512,
  parameter int CHANNEL_WIDTH  = 10,
  parameter int CHANNEL_TYPE   = CHANNEL_AFTER,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        start,
  input  logic        channel,
  input  logic        det_event,
  input  logic        clear_flags,
  messbauer_spectrum_collector_if.master rec,
  output logic [15:0] sweep_count,
  output logic        sync_error,
  output logic        overrun
);
  localparam bit                       IS_BEFORE = (CHANNEL_TYPE == CHANNEL_BEFORE);
  localparam logic [CHANNEL_WIDTH-1:0] LAST_IDX  = CHANNEL_WIDTH'(CHANNEL_NUMBER - 1);

  logic st_rise, ch_rise, ev_rise;

  messbauer_pulse_sync #(.SYNC_STAGES(0)) u_start (.clk(aclk), .rst_n(areset_n), .din(start),     .rise(st_rise));
  messbauer_pulse_sync #(.SYNC_STAGES(0)) u_chan  (.clk(aclk), .rst_n(areset_n), .din(channel),   .rise(ch_rise));
  messbauer_pulse_sync #(.SYNC_STAGES(2)) u_event (.clk(aclk), .rst_n(areset_n), .din(det_event), .rise(ev_rise));

  state_t                   state;
  logic [CHANNEL_WIDTH-1:0] idx;
  logic [COUNT_WIDTH-1:0]   acc, acc_inc;
  logic                     last, emit, err, ovr_set;

  // An event landing on the closing edge still belongs to the closing channel.
  assign acc_inc = (ev_rise && acc != '1) ? acc + COUNT_WIDTH'(1) : acc;
  assign last    = (idx == LAST_IDX);
  assign ovr_set = emit & rec.out_valid & ~rec.out_ready;

  always_comb begin
    emit = 1'b0;
    err  = 1'b0;
    if (st_rise) begin
      if (ch_rise) err = 1'b1;
      if (IS_BEFORE && state == ST_OPEN && last) emit = 1'b1;
      else if (state == ST_OPEN || state == ST_ARMED) err = 1'b1;
    end else if (ch_rise) begin
      case (state)
        ST_IDLE, ST_DONE: err = 1'b1;
        ST_OPEN: if (!IS_BEFORE || !last) emit = 1'b1;
                 else err = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state           <= ST_IDLE;
      idx             <= '0;
      acc             <= '0;
      sweep_count     <= '0;
      sync_error      <= 1'b0;
      overrun         <= 1'b0;
      rec.out_valid   <= 1'b0;
      rec.out_channel <= '0;
      rec.out_count   <= '0;
    end else begin
      if (st_rise) begin
        sweep_count <= sweep_count + 16'd1;
        state       <= IS_BEFORE ? ST_ARMED : ST_OPEN;
        idx         <= '0;
        acc         <= '0;
      end else if (ch_rise) begin
        case (state)
          ST_ARMED: begin
            state <= ST_OPEN;
            idx   <= '0;
            acc   <= '0;
          end
          ST_OPEN:
            if (emit) begin
              acc <= '0;
              if (last) state <= ST_DONE;
              else      idx   <= idx + CHANNEL_WIDTH'(1);
            end else begin
              acc <= acc_inc;
            end
          default: ;
        endcase
      end else if (state == ST_OPEN) begin
        acc <= acc_inc;
      end

      // Single-entry output register; a stalled record is never overwritten.
      if (emit && !ovr_set) begin
        rec.out_valid   <= 1'b1;
        rec.out_channel <= idx;
        rec.out_count   <= acc_inc;
      end else if (rec.out_ready) begin
        rec.out_valid <= 1'b0;
      end

      sync_error <= err     | (sync_error & ~clear_flags);
      overrun    <= ovr_set | (overrun    & ~clear_flags);
    end
  end
endmodule

// File: tb/tb_messbauer_spectrum_collector.sv
// Drives a type-1 and a type-2 collector with shared sweep stimulus and checks records and flags.
module tb_messbauer_spectrum_collector;
  import messbauer_pkg::*;

  localparam int CN  = 4;
  localparam int CW  = 2;
  localparam int NW  = 4;
  localparam int SAT = (1 << NW) - 1;
  localparam int P_IDLE = 0, P_ARMED = 1, P_OPEN = 2, P_DONE = 3;

  logic aclk = 1'b0, areset_n = 1'b1;
  logic start = 1'b0, channel = 1'b0, det_event = 1'b0, clear_flags = 1'b0, ready = 1'b1;
  logic [15:0] sweep1, sweep2;
  logic serr1, serr2, ovr1, ovr2;

  messbauer_spectrum_collector_if #(.CHANNEL_WIDTH(CW), .COUNT_WIDTH(NW)) if1 ();
  messbauer_spectrum_collector_if #(.CHANNEL_WIDTH(CW), .COUNT_WIDTH(NW)) if2 ();
  assign if1.out_ready = ready;
  assign if2.out_ready = ready;

  messbauer_spectrum_collector #(.CHANNEL_NUMBER(CN), .CHANNEL_WIDTH(CW),
    .CHANNEL_TYPE(CHANNEL_BEFORE), .COUNT_WIDTH(NW)) u_t1 (
    .aclk(aclk), .areset_n(areset_n), .start(start), .channel(channel), .det_event(det_event),
    .clear_flags(clear_flags), .rec(if1), .sweep_count(sweep1), .sync_error(serr1), .overrun(ovr1));

  messbauer_spectrum_collector #(.CHANNEL_NUMBER(CN), .CHANNEL_WIDTH(CW),
    .CHANNEL_TYPE(CHANNEL_AFTER), .COUNT_WIDTH(NW)) u_t2 (
    .aclk(aclk), .areset_n(areset_n), .start(start), .channel(channel), .det_event(det_event),
    .clear_flags(clear_flags), .rec(if2), .sweep_count(sweep2), .sync_error(serr2), .overrun(ovr2));

  always #5 aclk = ~aclk;

  typedef struct { int ch; int cnt; } rec_t;
  rec_t exp1[$], exp2[$], got1[$], got2[$];
  int phase[2], m_idx[2], m_acc[2], m_sweeps;
  bit m_sync[2], m_ovr[2], m_full[2];
  int checks = 0, errors = 0;

  int lit1_ch [16] = '{0,1,2,3, 0,1,2, 3,0,0, 1, 3,0,1, 0, 0};
  int lit1_cnt[16] = '{3,0,5,1, 1,1,1, 1,2,1, 2, 0,15,1, 0, 1};
  int lit2_ch [20] = '{0,1,2,3, 0,1,2,3, 0,1, 0,1, 2, 0,1,2, 0, 1, 0,1};
  int lit2_cnt[20] = '{2,3,0,5, 0,1,1,1, 4,2, 0,1, 2, 15,15,1, 0, 0, 2,1};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Transaction-level model: index 0 is the type-1 collector, index 1 the type-2 one.
  function automatic void m_emit(int t, int c, int v);
    rec_t r;
    r.ch = c; r.cnt = v;
    if (!ready && m_full[t]) begin m_ovr[t] = 1'b1; return; end
    if (!ready) m_full[t] = 1'b1;
    if (t == 0) exp1.push_back(r); else exp2.push_back(r);
  endfunction

  function automatic void m_start();
    m_sweeps = (m_sweeps + 1) % 65536;
    if (phase[0] == P_OPEN && m_idx[0] == CN - 1) m_emit(0, CN - 1, m_acc[0]);
    else if (phase[0] == P_OPEN || phase[0] == P_ARMED) m_sync[0] = 1'b1;
    if (phase[1] == P_OPEN || phase[1] == P_ARMED) m_sync[1] = 1'b1;
    phase[0] = P_ARMED;
    phase[1] = P_OPEN;
    for (int t = 0; t < 2; t++) begin m_idx[t] = 0; m_acc[t] = 0; end
  endfunction

  function automatic void m_chan();
    if (phase[0] == P_ARMED) begin
      phase[0] = P_OPEN; m_idx[0] = 0; m_acc[0] = 0;
    end else if (phase[0] == P_OPEN && m_idx[0] < CN - 1) begin
      m_emit(0, m_idx[0], m_acc[0]); m_idx[0]++; m_acc[0] = 0;
    end else m_sync[0] = 1'b1;
    if (phase[1] == P_OPEN) begin
      m_emit(1, m_idx[1], m_acc[1]); m_acc[1] = 0;
      if (m_idx[1] == CN - 1) phase[1] = P_DONE; else m_idx[1]++;
    end else m_sync[1] = 1'b1;
  endfunction

  function automatic void m_events(int n);
    for (int t = 0; t < 2; t++)
      if (phase[t] == P_OPEN) m_acc[t] = (m_acc[t] + n > SAT) ? SAT : m_acc[t] + n;
  endfunction

  function automatic void m_reset();
    exp1.delete(); exp2.delete();
    m_sweeps = 0;
    for (int t = 0; t < 2; t++) begin
      phase[t] = P_IDLE; m_idx[t] = 0; m_acc[t] = 0;
      m_sync[t] = 1'b0; m_ovr[t] = 1'b0; m_full[t] = 1'b0;
    end
  endfunction

  task automatic cmp_out(input int t, input logic v, input int c, input int n);
    rec_t r;
    if (!v) return;
    if ((t == 0 && exp1.size() == 0) || (t == 1 && exp2.size() == 0)) begin
      checks++; errors++;
      $display("FAIL t%0d record: got ch %0d cnt %0d required no record", t + 1, c, n);
      return;
    end
    r = (t == 0) ? exp1[0] : exp2[0];
    chk($sformatf("t%0d out_channel", t + 1), c, r.ch);
    chk($sformatf("t%0d out_count", t + 1), n, r.cnt);
    if (ready) begin
      r.ch = c; r.cnt = n;
      if (t == 0) begin got1.push_back(r); void'(exp1.pop_front()); end
      else        begin got2.push_back(r); void'(exp2.pop_front()); end
    end
  endtask

  always @(negedge aclk) if (areset_n) begin
    cmp_out(0, if1.out_valid, int'(if1.out_channel), int'(if1.out_count));
    cmp_out(1, if2.out_valid, int'(if2.out_channel), int'(if2.out_count));
  end

  task automatic tick(); @(posedge aclk); #1; endtask

  task automatic do_start();
    start = 1'b1; m_start(); tick(); start = 1'b0; tick();
  endtask

  task automatic do_chan();
    channel = 1'b1; m_chan(); tick(); channel = 1'b0; tick();
  endtask

  task automatic do_events(input int n);
    for (int i = 0; i < n; i++) begin det_event = 1'b1; tick(); det_event = 1'b0; tick(); end
    repeat (3) tick();
    m_events(n);
  endtask

  task automatic do_coincident();
    det_event = 1'b1; tick(); det_event = 1'b0; tick();
    channel = 1'b1; m_events(1); m_chan(); tick(); channel = 1'b0; tick();
  endtask

  task automatic do_simul();
    start = 1'b1; channel = 1'b1; m_start(); m_sync[0] = 1'b1; m_sync[1] = 1'b1;
    tick(); start = 1'b0; channel = 1'b0; tick();
  endtask

  task automatic do_clear();
    clear_flags = 1'b1; tick(); clear_flags = 1'b0;
    for (int t = 0; t < 2; t++) begin m_sync[t] = 1'b0; m_ovr[t] = 1'b0; end
  endtask

  task automatic set_ready(input logic v);
    ready = v;
    if (v) begin m_full[0] = 1'b0; m_full[1] = 1'b0; end
  endtask

  task automatic check_state(input string tag);
    @(negedge aclk);
    chk({tag, " t1 sweep_count"}, int'(sweep1), m_sweeps);
    chk({tag, " t2 sweep_count"}, int'(sweep2), m_sweeps);
    chk({tag, " t1 sync_error"}, int'(serr1), int'(m_sync[0]));
    chk({tag, " t2 sync_error"}, int'(serr2), int'(m_sync[1]));
    chk({tag, " t1 overrun"}, int'(ovr1), int'(m_ovr[0]));
    chk({tag, " t2 overrun"}, int'(ovr2), int'(m_ovr[1]));
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " t1 out_valid"}, int'(if1.out_valid), 0);
    chk({tag, " t2 out_valid"}, int'(if2.out_valid), 0);
    chk({tag, " t1 out_channel"}, int'(if1.out_channel), 0);
    chk({tag, " t2 out_count"}, int'(if2.out_count), 0);
    chk({tag, " t1 sweep_count"}, int'(sweep1), 0);
    chk({tag, " t2 sweep_count"}, int'(sweep2), 0);
    chk({tag, " t1 flags"}, int'({serr1, ovr1}), 0);
    chk({tag, " t2 flags"}, int'({serr2, ovr2}), 0);
  endtask

  initial begin
    m_reset();
    #1 areset_n = 1'b0;
    #2 chk_reset("reset");
    #9 areset_n = 1'b1;
    tick();

    // Sweep 1: the first closing edge also pins the one-cycle record latency.
    do_start(); do_events(2);
    channel = 1'b1; m_chan();
    @(negedge aclk); chk("latency valid cycle N", int'(if2.out_valid), 0);
    tick(); channel = 1'b0;
    @(negedge aclk); chk("latency valid cycle N+1", int'(if2.out_valid), 1);
    tick();
    @(negedge aclk); chk("latency valid drop N+2", int'(if2.out_valid), 0);
    tick();
    do_events(3); do_chan(); do_events(0); do_chan(); do_events(5); do_chan();
    do_events(1); do_start();
    check_state("sweep1");

    // Sweep 2: one channel pulse too many for both framings.
    do_chan();
    repeat (4) begin do_events(1); do_chan(); end
    check_state("extra channel");
    do_clear(); check_state("clear");

    // Sweep 3: early start after two channels, then restart from idx 0.
    do_start(); do_events(4); do_chan(); do_events(2); do_chan(); do_start();
    check_state("early start");
    do_chan(); do_events(1); do_chan(); do_clear();

    // Backpressure across two closures.
    set_ready(1'b0);
    do_events(2); do_chan(); do_events(3); do_chan();
    check_state("backpressure");
    repeat (3) tick();
    set_ready(1'b1); tick(); tick();
    do_clear(); check_state("after clear");

    // Saturation and an event coincident with the closing edge.
    do_start(); do_events(20); do_chan(); do_events(20); do_chan(); do_coincident();
    check_state("saturate");

    // Simultaneous start and channel.
    do_simul(); check_state("simultaneous");
    do_chan(); do_clear();

    // Asynchronous reset with a stalled record pending.
    do_chan(); set_ready(1'b0); do_events(1); do_chan();
    @(posedge aclk); #3 areset_n = 1'b0; m_reset();
    #1 chk_reset("mid reset");
    #3 areset_n = 1'b1;
    set_ready(1'b1); tick();
    do_start(); do_events(2); do_chan(); do_events(1); do_chan();
    check_state("after reset");
    repeat (2) tick();

    chk("t1 record total", got1.size(), 16);
    chk("t2 record total", got2.size(), 20);
    chk("t1 leftover", exp1.size(), 0);
    chk("t2 leftover", exp2.size(), 0);
    for (int i = 0; i < 16 && i < got1.size(); i++) begin
      chk($sformatf("t1 lit ch[%0d]", i), got1[i].ch, lit1_ch[i]);
      chk($sformatf("t1 lit cnt[%0d]", i), got1[i].cnt, lit1_cnt[i]);
    end
    for (int i = 0; i < 20 && i < got2.size(); i++) begin
      chk($sformatf("t2 lit ch[%0d]", i), got2[i].ch, lit2_ch[i]);
      chk($sformatf("t2 lit cnt[%0d]", i), got2[i].cnt, lit2_cnt[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
